ex_operand_stage: RTL

- ID/EX pipeline stage that sits directly upstream of the ALU.
- Registers decoded operands and control from ID.
- Resolves EX/MEM and MEM/WB forwarding on the registered operands, and decodes funct3/funct7/ALUOp into the ALU control code.
- Detects load-use hazards, inserts bubbles, and honours stall and flush from the hazard/branch logic.

---
 rtl/ex_operand_stage_pkg.sv | 29 ++
 rtl/ex_operand_stage_alu_ctrl_decode.sv | 52 +++++
 rtl/ex_operand_stage.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/ex_operand_stage_pkg.sv
// Shared constants for the ID/EX operand stage: widths, ALUOp and ALU control encodings.
package ex_operand_stage_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int CTRL_W = 4;

  // ALUOp classes produced by the main decoder
  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  // ALU operation codes consumed by the ALU
  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_SLL = 4'b0010,
    ALU_SLT = 4'b0011,
    ALU_XOR = 4'b0100,
    ALU_SRL = 4'b0101,
    ALU_SRA = 4'b0110,
    ALU_OR  = 4'b0111,
    ALU_AND = 4'b1000,
    ALU_BLT = 4'b1001,
    ALU_BGE = 4'b1010
  } alu_ctrl_e;

endpackage

// File: rtl/ex_operand_stage_alu_ctrl_decode.sv
// Combinational decode of ALUOp/funct3/funct7 into the ALU operation code.
module alu_ctrl_decode
  import ex_operand_stage_pkg::*;
#(
  parameter int CTRL_W = ex_operand_stage_pkg::CTRL_W
) (
  input  logic [1:0]        aluop_i,
  input  logic [2:0]        funct3_i,
  input  logic [6:0]        funct7_i,
  output logic [CTRL_W-1:0] ctrl_o
);

  alu_ctrl_e code;
  logic      alt;

  // Only funct7[5] selects the alternate (SUB/SRA) forms; other bits are ignored.
  logic unused_funct7_bits;
  assign unused_funct7_bits = ^{funct7_i[6], funct7_i[4:0]};
  assign alt = funct7_i[5];

  // Map the instruction class and function fields to one ALU operation
  always_comb begin
    code = ALU_ADD;
    case (aluop_i)
      ALUOP_MEM: code = ALU_ADD;
      ALUOP_BRANCH: begin
        case (funct3_i)
          3'b000, 3'b001: code = ALU_SUB;
          3'b100:         code = ALU_BLT;
          3'b101:         code = ALU_BGE;
          default:        code = ALU_ADD;
        endcase
      end
      default: begin
        // R-type and I-type ALU share the table; only R-type honours SUB
        case (funct3_i)
          3'b000:  code = (aluop_i == ALUOP_RTYPE && alt) ? ALU_SUB : ALU_ADD;
          3'b001:  code = ALU_SLL;
          3'b010:  code = ALU_SLT;
          3'b100:  code = ALU_XOR;
          3'b101:  code = alt ? ALU_SRA : ALU_SRL;
          3'b110:  code = ALU_OR;
          3'b111:  code = ALU_AND;
          default: code = ALU_ADD;
        endcase
      end
    endcase
  end

  assign ctrl_o = CTRL_W'(code);

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding, load-use detection and ALU control decode.
module ex_operand_stage
  import ex_operand_stage_pkg::*;
#(
  parameter int XLEN   = ex_operand_stage_pkg::XLEN,
  parameter int REG_AW = ex_operand_stage_pkg::REG_AW,
  parameter int CTRL_W = ex_operand_stage_pkg::CTRL_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [XLEN-1:0]   rs1_data_i,
  input  logic [XLEN-1:0]   rs2_data_i,
  input  logic [XLEN-1:0]   imm_i,
  input  logic [REG_AW-1:0] rs1_addr_i,
  input  logic [REG_AW-1:0] rs2_addr_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  input  logic [2:0]        funct3_i,
  input  logic [6:0]        funct7_i,
  input  logic [1:0]        ALUOp_i,
  input  logic              ALUSrc_i,
  input  logic              RegWrite_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  input  logic              exmem_RegWrite_i,
  input  logic              memwb_RegWrite_i,
  input  logic [XLEN-1:0]   exmem_data_i,
  input  logic [XLEN-1:0]   memwb_data_i,
  output logic [XLEN-1:0]   data1_o,
  output logic [XLEN-1:0]   data2_o,
  output logic [XLEN-1:0]   store_data_o,
  output logic [CTRL_W-1:0] ALUCtrl_o,
  output logic [XLEN-1:0]   pc_o,
  output logic [REG_AW-1:0] rd_addr_o,
  output logic              RegWrite_o,
  output logic              MemRead_o,
  output logic              MemWrite_o,
  output logic              valid_o,
  output logic              hazard_o
);

  // Stage registers; index 0 is rs1, index 1 is rs2
  logic              valid_q,    valid_d;
  logic [XLEN-1:0]   pc_q,       pc_d;
  logic [XLEN-1:0]   imm_q,      imm_d;
  logic [REG_AW-1:0] rd_q,       rd_d;
  logic              alusrc_q,   alusrc_d;
  logic              regwrite_q, regwrite_d;
  logic              memread_q,  memread_d;
  logic              memwrite_q, memwrite_d;
  logic [CTRL_W-1:0] aluctrl_q,  aluctrl_d;
  logic [XLEN-1:0]   rs_data_q [2];
  logic [XLEN-1:0]   rs_data_d [2];
  logic [REG_AW-1:0] rs_addr_q [2];
  logic [REG_AW-1:0] rs_addr_d [2];

  logic [CTRL_W-1:0] aluctrl_dec;
  logic              hazard;

  alu_ctrl_decode #(
    .CTRL_W (CTRL_W)
  ) u_alu_ctrl_decode (
    .aluop_i  (ALUOp_i),
    .funct3_i (funct3_i),
    .funct7_i (funct7_i),
    .ctrl_o   (aluctrl_dec)
  );

  // Load-use: the load now in EX writes a register the ID instruction reads
  always_comb begin
    hazard = valid_i & valid_q & memread_q & (rd_q != '0) &
             ((rd_q == rs1_addr_i) | (rd_q == rs2_addr_i));
  end

  assign hazard_o = hazard;

  // Next-state: flush beats stall, stall beats the load-use bubble, else load ID
  always_comb begin
    valid_d      = valid_q;
    pc_d         = pc_q;
    imm_d        = imm_q;
    rd_d         = rd_q;
    alusrc_d     = alusrc_q;
    regwrite_d   = regwrite_q;
    memread_d    = memread_q;
    memwrite_d   = memwrite_q;
    aluctrl_d    = aluctrl_q;
    rs_data_d[0] = rs_data_q[0];
    rs_data_d[1] = rs_data_q[1];
    rs_addr_d[0] = rs_addr_q[0];
    rs_addr_d[1] = rs_addr_q[1];
    if (flush_i || (!stall_i && hazard)) begin
      valid_d      = 1'b0;
      pc_d         = '0;
      imm_d        = '0;
      rd_d         = '0;
      alusrc_d     = 1'b0;
      regwrite_d   = 1'b0;
      memread_d    = 1'b0;
      memwrite_d   = 1'b0;
      aluctrl_d    = '0;
      rs_data_d[0] = '0;
      rs_data_d[1] = '0;
      rs_addr_d[0] = '0;
      rs_addr_d[1] = '0;
    end else if (!stall_i) begin
      // A non-instruction in ID must not write, access memory or drive the ALU
      valid_d      = valid_i;
      pc_d         = pc_i;
      imm_d        = imm_i;
      rd_d         = rd_addr_i;
      alusrc_d     = ALUSrc_i;
      regwrite_d   = valid_i & RegWrite_i;
      memread_d    = valid_i & MemRead_i;
      memwrite_d   = valid_i & MemWrite_i;
      aluctrl_d    = valid_i ? aluctrl_dec : '0;
      rs_data_d[0] = rs1_data_i;
      rs_data_d[1] = rs2_data_i;
      rs_addr_d[0] = rs1_addr_i;
      rs_addr_d[1] = rs2_addr_i;
    end
  end

  // Stage register update with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q      <= 1'b0;
      pc_q         <= '0;
      imm_q        <= '0;
      rd_q         <= '0;
      alusrc_q     <= 1'b0;
      regwrite_q   <= 1'b0;
      memread_q    <= 1'b0;
      memwrite_q   <= 1'b0;
      aluctrl_q    <= '0;
      rs_data_q[0] <= '0;
      rs_data_q[1] <= '0;
      rs_addr_q[0] <= '0;
      rs_addr_q[1] <= '0;
    end else begin
      valid_q      <= valid_d;
      pc_q         <= pc_d;
      imm_q        <= imm_d;
      rd_q         <= rd_d;
      alusrc_q     <= alusrc_d;
      regwrite_q   <= regwrite_d;
      memread_q    <= memread_d;
      memwrite_q   <= memwrite_d;
      aluctrl_q    <= aluctrl_d;
      rs_data_q[0] <= rs_data_d[0];
      rs_data_q[1] <= rs_data_d[1];
      rs_addr_q[0] <= rs_addr_d[0];
      rs_addr_q[1] <= rs_addr_d[1];
    end
  end

  // One forwarding mux per source operand; EX/MEM is newer so it wins, x0 never forwards
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      logic [XLEN-1:0] fwd;
      always_comb begin
        fwd = rs_data_q[gi];
        if (exmem_RegWrite_i && (exmem_rd_i != '0) && (exmem_rd_i == rs_addr_q[gi])) begin
          fwd = exmem_data_i;
        end else if (memwb_RegWrite_i && (memwb_rd_i != '0) && (memwb_rd_i == rs_addr_q[gi])) begin
          fwd = memwb_data_i;
        end
      end
    end
  endgenerate

  assign data1_o      = g_fwd[0].fwd;
  assign data2_o      = alusrc_q ? imm_q : g_fwd[1].fwd;
  assign store_data_o = g_fwd[1].fwd;
  assign ALUCtrl_o    = aluctrl_q;
  assign pc_o         = pc_q;
  assign rd_addr_o    = rd_q;
  assign RegWrite_o   = regwrite_q;
  assign MemRead_o    = memread_q;
  assign MemWrite_o   = memwrite_q;
  assign valid_o      = valid_q;

endmodule
